dual_issue_stage: RTL

Issue/pipeline-register stage that drives both lanes of the dual-ALU execute stage. It accepts a decoded instruction pair from decode and checks for an intra-pair RAW dependency. Independent pairs issue together; a dependent pair is split over two cycles, and lane 2's operand is patched from the lane-1 ALU result. All outputs are registered and feed the execute-stage operand muxes directly.

---
 rtl/dual_issue_pkg.sv | 28 ++
 rtl/dual_issue_hazard.sv | 24 ++
 rtl/dual_issue_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dual_issue_pkg.sv
// Shared types and widths for the dual-issue stage and its hazard checker.
package dual_issue_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned MUX_W    = 2;
  localparam int unsigned ALU_FN_W = 4;

  localparam logic [MUX_W-1:0] MUX_REG   = 2'd0;
  localparam logic [MUX_W-1:0] MUX_IMM   = 2'd1;
  localparam logic [MUX_W-1:0] MUX_SHAMT = 2'd2;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]   data_a;
    logic [DATA_W-1:0]   data_b;
    logic [DATA_W-1:0]   imm;
    logic [SHAMT_W-1:0]  shamt;
    logic [MUX_W-1:0]    mux;
    logic [ALU_FN_W-1:0] alu_fn;
  } lane_t;

endpackage

// File: rtl/dual_issue_hazard.sv
// Intra-pair RAW detection: lane 2 reads the register lane 1 writes.
module dual_issue_hazard
  import dual_issue_pkg::*;
(
  input  logic             valid_1,
  input  logic             valid_2,
  input  logic             wr_1,
  input  logic [REG_W-1:0] rd_1,
  input  logic [REG_W-1:0] rs_2,
  input  logic [REG_W-1:0] rt_2,
  input  logic [MUX_W-1:0] mux_2,
  output logic             hz_c,
  output logic             fwd_a_c,
  output logic             fwd_b_c
);

  // rt only matters when lane 2 actually selects the register operand for B
  always_comb begin
    fwd_a_c = (rs_2 == rd_1);
    fwd_b_c = (rt_2 == rd_1) && (mux_2 == MUX_REG);
    hz_c    = valid_1 && valid_2 && wr_1 && (rd_1 != '0) && (fwd_a_c || fwd_b_c);
  end

endmodule

// File: rtl/dual_issue_stage.sv
// Issue register stage for the dual-ALU execute; splits RAW-dependent pairs over two cycles.
module dual_issue_stage
  import dual_issue_pkg::*;
#(
  parameter int unsigned SPLIT_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_1,
  input  logic                   in_valid_2,
  output logic                   in_ready,
  input  logic [REG_W-1:0]       in_rs_1,
  input  logic [REG_W-1:0]       in_rt_1,
  input  logic [REG_W-1:0]       in_rd_1,
  input  logic [REG_W-1:0]       in_rs_2,
  input  logic [REG_W-1:0]       in_rt_2,
  input  logic [REG_W-1:0]       in_rd_2,
  input  logic                   in_wr_1,
  input  logic                   in_wr_2,
  input  logic [DATA_W-1:0]      in_data_A_1,
  input  logic [DATA_W-1:0]      in_data_B_1,
  input  logic [DATA_W-1:0]      in_SignExtImm_1,
  input  logic [DATA_W-1:0]      in_data_A_2,
  input  logic [DATA_W-1:0]      in_data_B_2,
  input  logic [DATA_W-1:0]      in_SignExtImm_2,
  input  logic [SHAMT_W-1:0]     in_shamt_1,
  input  logic [SHAMT_W-1:0]     in_shamt_2,
  input  logic [MUX_W-1:0]       in_mux_1_flag_1,
  input  logic [MUX_W-1:0]       in_mux_1_flag_2,
  input  logic [ALU_FN_W-1:0]    in_Alu_function_1,
  input  logic [ALU_FN_W-1:0]    in_Alu_function_2,
  input  logic                   ex_stall,
  input  logic [DATA_W-1:0]      alu_1_result,
  output logic [DATA_W-1:0]      data_A_1,
  output logic [DATA_W-1:0]      data_B_1,
  output logic [DATA_W-1:0]      SignExtImm_1,
  output logic [SHAMT_W-1:0]     shamt_1,
  output logic [MUX_W-1:0]       mux_1_flag_1,
  output logic [ALU_FN_W-1:0]    Alu_function_1,
  output logic [DATA_W-1:0]      data_A_2,
  output logic [DATA_W-1:0]      data_B_2,
  output logic [DATA_W-1:0]      SignExtImm_2,
  output logic [SHAMT_W-1:0]     shamt_2,
  output logic [MUX_W-1:0]       mux_1_flag_2,
  output logic [ALU_FN_W-1:0]    Alu_function_2,
  output logic                   valid_1,
  output logic                   valid_2,
  output logic [SPLIT_CNT_W-1:0] split_cnt
);

  state_e                 state_q, state_d;
  lane_t                  lane1_q, lane1_d, lane2_q, lane2_d, hold_q, hold_d;
  logic                   valid_1_q, valid_1_d, valid_2_q, valid_2_d;
  logic                   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [SPLIT_CNT_W-1:0] split_cnt_q, split_cnt_d;
  lane_t                  in_lane1_c, in_lane2_c;
  logic                   hz_c, fwd_a_c, fwd_b_c;
  logic                   unused_ok_c;

  // Lane-1 sources and lane-2 destination play no part in issue decisions
  assign unused_ok_c = ^{in_rs_1, in_rt_1, in_rd_2, in_wr_2};

  assign in_lane1_c = '{in_data_A_1, in_data_B_1, in_SignExtImm_1, in_shamt_1,
                        in_mux_1_flag_1, in_Alu_function_1};
  assign in_lane2_c = '{in_data_A_2, in_data_B_2, in_SignExtImm_2, in_shamt_2,
                        in_mux_1_flag_2, in_Alu_function_2};

  dual_issue_hazard u_hazard (
    .valid_1 (in_valid_1),
    .valid_2 (in_valid_2),
    .wr_1    (in_wr_1),
    .rd_1    (in_rd_1),
    .rs_2    (in_rs_2),
    .rt_2    (in_rt_2),
    .mux_2   (in_mux_1_flag_2),
    .hz_c    (hz_c),
    .fwd_a_c (fwd_a_c),
    .fwd_b_c (fwd_b_c)
  );

  assign in_ready = (state_q == ST_PAIR) && !ex_stall;

  // Next-state and register update; everything holds while execute is stalled
  always_comb begin
    state_d     = state_q;
    lane1_d     = lane1_q;
    lane2_d     = lane2_q;
    hold_d      = hold_q;
    valid_1_d   = valid_1_q;
    valid_2_d   = valid_2_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    split_cnt_d = split_cnt_q;
    if (!ex_stall) begin
      case (state_q)
        ST_PAIR: begin
          if (in_valid_1) begin
            lane1_d   = in_lane1_c;
            valid_1_d = 1'b1;
            if (hz_c) begin
              valid_2_d = 1'b0;
              hold_d    = in_lane2_c;
              fwd_a_d   = fwd_a_c;
              fwd_b_d   = fwd_b_c;
              state_d   = ST_SPLIT;
              if (split_cnt_q != '1) split_cnt_d = split_cnt_q + SPLIT_CNT_W'(1);
            end else begin
              lane2_d   = in_lane2_c;
              valid_2_d = in_valid_2;
            end
          end else begin
            valid_1_d = 1'b0;
            valid_2_d = 1'b0;
          end
        end
        ST_SPLIT: begin
          // Lane 1 is in execute this cycle, so its result patches lane 2
          lane2_d = hold_q;
          if (fwd_a_q) lane2_d.data_a = alu_1_result;
          if (fwd_b_q) lane2_d.data_b = alu_1_result;
          valid_1_d = 1'b0;
          valid_2_d = 1'b1;
          state_d   = ST_PAIR;
        end
        default: state_d = ST_PAIR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PAIR;
      lane1_q     <= '0;
      lane2_q     <= '0;
      hold_q      <= '0;
      valid_1_q   <= 1'b0;
      valid_2_q   <= 1'b0;
      fwd_a_q     <= 1'b0;
      fwd_b_q     <= 1'b0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lane1_q     <= lane1_d;
      lane2_q     <= lane2_d;
      hold_q      <= hold_d;
      valid_1_q   <= valid_1_d;
      valid_2_q   <= valid_2_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign data_A_1       = lane1_q.data_a;
  assign data_B_1       = lane1_q.data_b;
  assign SignExtImm_1   = lane1_q.imm;
  assign shamt_1        = lane1_q.shamt;
  assign mux_1_flag_1   = lane1_q.mux;
  assign Alu_function_1 = lane1_q.alu_fn;
  assign data_A_2       = lane2_q.data_a;
  assign data_B_2       = lane2_q.data_b;
  assign SignExtImm_2   = lane2_q.imm;
  assign shamt_2        = lane2_q.shamt;
  assign mux_1_flag_2   = lane2_q.mux;
  assign Alu_function_2 = lane2_q.alu_fn;
  assign valid_1        = valid_1_q;
  assign valid_2        = valid_2_q;
  assign split_cnt      = split_cnt_q;

endmodule
